regfile_multiport: RTL and testbench

- Parametrised successor to the pipeline's 32x32 register file.
- Configurable data width, register count and number of combinational read ports.
- Writes on posedge with same-cycle write-to-read bypass; replaces the negedge-write scheme.
- Adds per-register valid bits (async reset makes every register read as zero without resetting the array), plus a busy-bit scoreboard that decode uses for RAW-hazard stalls.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 67 ++++++
 rtl/regfile_multiport.sv | 92 +++++++++
 tb/tb_regfile_multiport.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file and its busy scoreboard.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;
    localparam int ZERO_ADDR  = 0;

    // Low bit of port `port` inside a flattened bus of `width`-bit lanes.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register marking a pending producer, with per-port lookup.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     regWrite,
    input  logic [ADDR_W-1:0]        writeReg,
    input  logic                     markEn,
    input  logic [ADDR_W-1:0]        markReg,
    input  logic                     flush,
    input  logic [NUM_RD*ADDR_W-1:0] rdAddr,
    output logic [NUM_RD-1:0]        rdBusy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Flush beats everything; a new mark beats the clear from a completing write.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush) begin
                busy_d[i] = 1'b0;
            end else if (markEn && markReg == ADDR_W'(i)) begin
                busy_d[i] = 1'b1;
            end else if (regWrite && writeReg == ADDR_W'(i)) begin
                busy_d[i] = 1'b0;
            end
            if (ZERO_REG != 0 && i == ZERO_ADDR) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
        localparam int LO = slice_lo(gi, ADDR_W);
        logic [ADDR_W-1:0] addr;
        assign addr = rdAddr[LO +: ADDR_W];

        always_comb begin
            if (ZERO_REG != 0 && addr == ADDR_W'(ZERO_ADDR)) begin
                rdBusy[gi] = 1'b0;
            end else if (BYPASS != 0 && regWrite && writeReg == addr) begin
                rdBusy[gi] = 1'b0;
            end else begin
                rdBusy[gi] = busy_q[addr];
            end
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file: posedge write, combinational reads with optional bypass,
// per-register valid bits so reset reads as zero without clearing the array.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     regWrite,
    input  logic [ADDR_W-1:0]        writeReg,
    input  logic [DATA_W-1:0]        writeData,
    input  logic [NUM_RD*ADDR_W-1:0] rdAddr,
    output logic [NUM_RD*DATA_W-1:0] rdData,
    output logic [NUM_RD-1:0]        rdBusy,
    input  logic                     markEn,
    input  logic [ADDR_W-1:0]        markReg,
    input  logic                     flush
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;
    logic              wr_en;

    assign wr_en = regWrite && !(ZERO_REG != 0 && writeReg == ADDR_W'(ZERO_ADDR));

    // Array is deliberately left unreset; valid_q masks stale contents after reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[writeReg] <= writeData;
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[writeReg] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        localparam int ALO = slice_lo(gi, ADDR_W);
        localparam int DLO = slice_lo(gi, DATA_W);
        logic [ADDR_W-1:0] addr;
        assign addr = rdAddr[ALO +: ADDR_W];

        always_comb begin
            if (ZERO_REG != 0 && addr == ADDR_W'(ZERO_ADDR)) begin
                rdData[DLO +: DATA_W] = '0;
            end else if (BYPASS != 0 && regWrite && writeReg == addr) begin
                rdData[DLO +: DATA_W] = writeData;
            end else if (!valid_q[addr]) begin
                rdData[DLO +: DATA_W] = '0;
            end else begin
                rdData[DLO +: DATA_W] = mem_q[addr];
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .regWrite (regWrite),
        .writeReg (writeReg),
        .markEn   (markEn),
        .markReg  (markReg),
        .flush    (flush),
        .rdAddr   (rdAddr),
        .rdBusy   (rdBusy)
    );

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: directed scenarios plus randomized traffic against an array model.
module tb_regfile_multiport;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 1 << AW;

    logic            clk = 1'b0;
    logic            rst;
    logic            regWrite;
    logic [AW-1:0]   writeReg;
    logic [DW-1:0]   writeData;
    logic [NR*AW-1:0] rdAddr;
    logic [NR*DW-1:0] rdData;
    logic [NR-1:0]   rdBusy;
    logic            markEn;
    logic [AW-1:0]   markReg;
    logic            flush;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference state: what each register holds, whether it was written since reset, whether reserved.
    logic [DW-1:0] m_mem   [DEPTH];
    bit            m_valid [DEPTH];
    bit            m_busy  [DEPTH];

    regfile_multiport #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk(clk), .rst(rst), .regWrite(regWrite), .writeReg(writeReg),
        .writeData(writeData), .rdAddr(rdAddr), .rdData(rdData), .rdBusy(rdBusy),
        .markEn(markEn), .markReg(markReg), .flush(flush)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "timeout");
    end

    function automatic logic [DW-1:0] port_data(input int p);
        return rdData[p*DW +: DW];
    endfunction

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rdAddr[p*AW +: AW] = a;
    endtask

    task automatic set_idle();
        regWrite  = 1'b0;
        writeReg  = '0;
        writeData = '0;
        markEn    = 1'b0;
        markReg   = '0;
        flush     = 1'b0;
        rdAddr    = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 0;
            m_busy[i]  = 0;
        end
    endtask

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (regWrite && writeReg == a) return writeData;
        if (!m_valid[a]) return '0;
        return m_mem[a];
    endfunction

    function automatic logic model_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (regWrite && writeReg == a) return 1'b0;
        return m_busy[a];
    endfunction

    // One clock: DUT samples at posedge, model applies the same edge, inputs change after negedge.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            if (regWrite && writeReg != 0) begin
                m_mem[writeReg]   = writeData;
                m_valid[writeReg] = 1;
                m_busy[writeReg]  = 0;
            end
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
            end else if (markEn && markReg != 0) begin
                m_busy[markReg] = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        model_reset();
        #1;
        tests_run++;
        if (rdData !== '0 || rdBusy !== '0) begin
            tests_failed++;
            $display("FAIL reset_hold: rdData=%h rdBusy=%b, required 0 / 00", rdData, rdBusy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        set_rd(0, 5'd3);
        set_rd(1, 5'd7);
        #1;
        tests_run++;
        if (port_data(0) !== 32'h0 || port_data(1) !== 32'h0 || rdBusy !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_release: d0=%h d1=%h busy=%b, required 0 0 00",
                     port_data(0), port_data(1), rdBusy);
        end
        $display("[TB] reset: read r3=%h r7=%h busy=%b", port_data(0), port_data(1), rdBusy);
    endtask

    task automatic test_write_bypass();
        set_idle();
        regWrite = 1'b1; writeReg = 5'd5; writeData = 32'hDEADBEEF;
        set_rd(0, 5'd7);
        set_rd(1, 5'd5);
        #1;
        tests_run++;
        if (port_data(1) !== 32'hDEADBEEF || rdBusy[1] !== 1'b0 || port_data(0) !== 32'h0) begin
            tests_failed++;
            $display("FAIL bypass_same_cycle: d1=%h busy1=%b d0=%h, required deadbeef 0 0",
                     port_data(1), rdBusy[1], port_data(0));
        end
        tick();
        set_idle();
        set_rd(0, 5'd5);
        #1;
        tests_run++;
        if (port_data(0) !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL write_next_cycle: d0=%h, required deadbeef", port_data(0));
        end
        $display("[TB] write r5: next-cycle read=%h", port_data(0));
    endtask

    task automatic test_zero_reg();
        set_idle();
        regWrite = 1'b1; writeReg = 5'd0; writeData = 32'h1234;
        markEn = 1'b1; markReg = 5'd0;
        #1;
        tests_run++;
        if (rdData !== '0 || rdBusy !== 2'b00) begin
            tests_failed++;
            $display("FAIL zero_same_cycle: rdData=%h busy=%b, required 0 00", rdData, rdBusy);
        end
        tick();
        set_idle();
        #1;
        tests_run++;
        if (rdData !== '0 || rdBusy !== 2'b00) begin
            tests_failed++;
            $display("FAIL zero_after: rdData=%h busy=%b, required 0 00", rdData, rdBusy);
        end
        $display("[TB] zero reg: read=%h busy=%b", port_data(0), rdBusy);
    endtask

    task automatic test_mark_busy();
        set_idle();
        markEn = 1'b1; markReg = 5'd9;
        tick();
        set_idle();
        set_rd(0, 5'd9);
        #1;
        tests_run++;
        if (rdBusy[0] !== 1'b1 || port_data(0) !== 32'h0) begin
            tests_failed++;
            $display("FAIL mark_sets_busy: busy0=%b d0=%h, required 1 0", rdBusy[0], port_data(0));
        end
        regWrite = 1'b1; writeReg = 5'd9; writeData = 32'h55;
        #1;
        tests_run++;
        if (rdBusy[0] !== 1'b0 || port_data(0) !== 32'h55) begin
            tests_failed++;
            $display("FAIL writeback_forward: busy0=%b d0=%h, required 0 55", rdBusy[0], port_data(0));
        end
        tick();
        set_idle();
        set_rd(0, 5'd9);
        #1;
        tests_run++;
        if (rdBusy[0] !== 1'b0 || port_data(0) !== 32'h55) begin
            tests_failed++;
            $display("FAIL writeback_clears: busy0=%b d0=%h, required 0 55", rdBusy[0], port_data(0));
        end
        $display("[TB] mark r9 then write 0x55: read=%h busy=%b", port_data(0), rdBusy[0]);
    endtask

    task automatic test_mark_write_flush();
        set_idle();
        markEn = 1'b1; markReg = 5'd4;
        regWrite = 1'b1; writeReg = 5'd4; writeData = 32'hA5;
        tick();
        set_idle();
        set_rd(0, 5'd4);
        #1;
        tests_run++;
        if (port_data(0) !== 32'hA5 || rdBusy[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL mark_write_same: d0=%h busy0=%b, required a5 1", port_data(0), rdBusy[0]);
        end
        flush = 1'b1;
        markEn = 1'b1; markReg = 5'd6;
        tick();
        set_idle();
        set_rd(0, 5'd4);
        set_rd(1, 5'd6);
        #1;
        tests_run++;
        if (rdBusy !== 2'b00 || port_data(0) !== 32'hA5) begin
            tests_failed++;
            $display("FAIL flush: busy=%b d0=%h, required 00 a5", rdBusy, port_data(0));
        end
        $display("[TB] mark+write r4 then flush: read=%h busy=%b", port_data(0), rdBusy);
    endtask

    task automatic test_async_reset();
        set_idle();
        regWrite = 1'b1; writeReg = 5'd2; writeData = 32'h77;
        markEn = 1'b1; markReg = 5'd3;
        tick();
        set_idle();
        set_rd(0, 5'd2);
        set_rd(1, 5'd3);
        #1;
        tests_run++;
        if (port_data(0) !== 32'h77 || rdBusy !== 2'b10) begin
            tests_failed++;
            $display("FAIL pre_reset: d0=%h busy=%b, required 77 10", port_data(0), rdBusy);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        tests_run++;
        if (port_data(0) !== 32'h0 || rdBusy !== 2'b00) begin
            tests_failed++;
            $display("FAIL async_reset: d0=%h busy=%b, required 0 00", port_data(0), rdBusy);
        end
        regWrite = 1'b1; writeReg = 5'd8; writeData = 32'h42;
        tick();
        set_idle();
        rst = 1'b0;
        set_rd(0, 5'd2);
        set_rd(1, 5'd8);
        #1;
        tests_run++;
        if (port_data(0) !== 32'h0 || port_data(1) !== 32'h0 || rdBusy !== 2'b00) begin
            tests_failed++;
            $display("FAIL post_reset: d2=%h d8=%h busy=%b, required 0 0 00",
                     port_data(0), port_data(1), rdBusy);
        end
        $display("[TB] async reset: r2=%h r8=%h after release", port_data(0), port_data(1));
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            regWrite  = ($urandom_range(0, 2) != 0);
            writeReg  = AW'($urandom_range(0, 7));
            writeData = $urandom;
            markEn    = ($urandom_range(0, 2) == 0);
            markReg   = AW'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 15) == 0);
            for (int p = 0; p < NR; p++) set_rd(p, AW'($urandom_range(0, 7)));
            #1;
            for (int p = 0; p < NR; p++) begin
                logic [AW-1:0] a;
                a = rdAddr[p*AW +: AW];
                tests_run++;
                if (port_data(p) !== model_rd(a) || rdBusy[p] !== model_busy(a)) begin
                    tests_failed++;
                    $display("FAIL random[%0d] port%0d addr=%0d: data=%h busy=%b, required %h %b",
                             n, p, a, port_data(p), rdBusy[p], model_rd(a), model_busy(a));
                end
            end
            $display("[TB] rand %0d: we=%b wr=%0d mk=%b mr=%0d fl=%b rd=%0d/%0d -> %h/%h busy=%b",
                     n, regWrite, writeReg, markEn, markReg, flush,
                     rdAddr[AW-1:0], rdAddr[2*AW-1:AW], port_data(0), port_data(1), rdBusy);
            tick();
        end
        set_idle();
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        @(negedge clk);
        test_reset();
        test_write_bypass();
        test_zero_reg();
        test_mark_busy();
        test_mark_write_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
